vmem_arbiter: RTL

Single-port video-memory controller between the VGA scan-out path and a host pixel-write path. It owns the frame buffer's only port (640x480, 24-bit RGB, address {y[8:0], x[9:0]}). It gives scan-out reads absolute priority, buffers host writes in a small FIFO and drains them in scan-idle cycles. It also runs a whole-frame fill engine for screen clears.

---
 rtl/vmem_pkg.sv | 24 ++
 rtl/sync_fifo.sv | 57 +++++
 rtl/vmem_arbiter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/vmem_pkg.sv
// rtl/vmem_pkg.sv - shared widths, FSM state type and address packing for vmem_arbiter
package vmem_pkg;

  localparam int ADDR_W = 19;
  localparam int PIX_W  = 24;
  localparam int H_W    = 10;
  localparam int V_W    = 10;

  // Host queue entry layout: {x, y, color}
  localparam int ENTRY_W = H_W + V_W + PIX_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FILL  = 2'd2
  } state_t;

  // Frame-buffer address is {y[8:0], x[9:0]}; y is truncated, no multiply.
  function automatic logic [ADDR_W-1:0] pack_addr(input logic [H_W-1:0] x,
                                                  input logic [V_W-1:0] y);
    return {y[8:0], x};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word-fall-through synchronous FIFO
module sync_fifo #(
  parameter int WIDTH = 44,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] slots [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      count;
  logic             do_pop;
  logic             do_push;

  // A full FIFO may still take a push when the head leaves in the same cycle.
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign full     = (count == FULL_COUNT);
  assign empty    = (count == '0);
  assign pop_data = slots[rd_ptr];

  // Entry storage; contents are don't-care until counted as valid.
  always_ff @(posedge clock) begin
    if (do_push) begin
      slots[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vmem_arbiter.sv
// rtl/vmem_arbiter.sv - single-port frame-buffer arbiter: scan-out reads, fill engine, host write queue
module vmem_arbiter
  import vmem_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              scan_en,
  input  logic [H_W-1:0]    scan_h,
  input  logic [V_W-1:0]    scan_v,
  output logic              pix_valid,
  output logic [PIX_W-1:0]  pix_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [H_W-1:0]    wr_x,
  input  logic [V_W-1:0]    wr_y,
  input  logic [PIX_W-1:0]  wr_color,
  input  logic              fill_start,
  input  logic [PIX_W-1:0]  fill_color,
  output logic              busy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [PIX_W-1:0]  mem_wdata,
  input  logic [PIX_W-1:0]  mem_rdata
);

  localparam logic [H_W-1:0] H_LIM  = H_W'(H_ACTIVE);
  localparam logic [V_W-1:0] V_LIM  = V_W'(V_ACTIVE);
  localparam logic [H_W-1:0] X_LAST = H_W'(H_ACTIVE - 1);
  localparam logic [V_W-1:0] Y_LAST = V_W'(V_ACTIVE - 1);

  state_t             state;
  state_t             state_next;
  logic [H_W-1:0]     fill_x;
  logic [V_W-1:0]     fill_y;
  logic [PIX_W-1:0]   fill_rgb;
  logic               fill_accept;
  logic               fill_step;
  logic               fill_last;
  logic               drain_step;
  logic               push;
  logic               full;
  logic               empty;
  logic [ENTRY_W-1:0] head;
  logic [H_W-1:0]     head_x;
  logic [V_W-1:0]     head_y;
  logic [PIX_W-1:0]   head_color;

  assign busy        = (state == FILL);
  assign wr_ready    = ~full;
  assign push        = wr_valid & wr_ready & (wr_x < H_LIM) & (wr_y < V_LIM);
  assign fill_accept = fill_start & ~busy & ~reset;
  // Scan owns the port whenever it asks; fill and drain simply wait.
  assign fill_step   = busy & ~scan_en & ~reset;
  assign drain_step  = ~busy & ~empty & ~scan_en & ~reset;
  assign fill_last   = (fill_x == X_LAST) && (fill_y == Y_LAST);
  assign {head_x, head_y, head_color} = head;
  assign pix_data    = pix_valid ? mem_rdata : '0;

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_host_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data ({wr_x, wr_y, wr_color}),
    .pop       (drain_step),
    .pop_data  (head),
    .full      (full),
    .empty     (empty)
  );

  // RAM port mux: scan read, else fill write, else queued host write.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (!reset) begin
      if (scan_en) begin
        mem_en   = 1'b1;
        mem_addr = pack_addr(scan_h, scan_v);
      end else if (fill_step) begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = pack_addr(fill_x, fill_y);
        mem_wdata = fill_rgb;
      end else if (drain_step) begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = pack_addr(head_x, head_y);
        mem_wdata = head_color;
      end
    end
  end

  // Next-state selection; queued entries survive a fill and drain afterwards.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DRAIN: begin
        if (fill_accept)  state_next = FILL;
        else if (!empty)  state_next = DRAIN;
        else              state_next = IDLE;
      end
      FILL: begin
        if (fill_step && fill_last) state_next = empty ? IDLE : DRAIN;
      end
      default: state_next = IDLE;
    endcase
  end

  // State, raster fill counters and scan-valid pipeline register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      fill_x    <= '0;
      fill_y    <= '0;
      fill_rgb  <= '0;
      pix_valid <= 1'b0;
    end else begin
      state     <= state_next;
      pix_valid <= scan_en;
      if (fill_accept) begin
        fill_x   <= '0;
        fill_y   <= '0;
        fill_rgb <= fill_color;
      end else if (fill_step) begin
        if (fill_x == X_LAST) begin
          fill_x <= '0;
          fill_y <= fill_last ? '0 : fill_y + 1'b1;
        end else begin
          fill_x <= fill_x + 1'b1;
        end
      end
    end
  end

endmodule
